trigger_sequencer: RTL and testbench

Multi-channel trigger scheduler for the interlock-and-trigger system. It runs a period counter and drives each trigger_out channel with a programmable delay/width window inside every period, for a burst of N periods or continuously. Configuration is latched at start. Any interlock drop forces all triggers low immediately and latches a fault.

---
 rtl/trigger_sequencer_if.sv | 39 +++
 rtl/trigger_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_trigger_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trigger_sequencer_if.sv
// trigger_sequencer_if
// Groups the run-control, configuration and status signals of the trigger
// sequencer into one bundle.
//   master : drives enable/start/clear_fault/interlock_ok and the configuration,
//            and observes trigger_out, counter, trigger_number_fixed,
//            busy, done and fault
//   slave  : the sequencer side (inverse directions)
interface trigger_sequencer_if #(
    parameter int CH    = 4,
    parameter int CNT_W = 32,
    parameter int NUM_W = 32
);
    logic                  enable;
    logic                  start;
    logic                  clear_fault;
    logic                  interlock_ok;
    logic [CNT_W-1:0]      period;
    logic [NUM_W-1:0]      num_triggers;
    logic [CH*CNT_W-1:0]   delay;
    logic [CH*CNT_W-1:0]   width;
    logic [CH-1:0]         trigger_out;
    logic [CNT_W-1:0]      counter;
    logic [NUM_W-1:0]      trigger_number_fixed;
    logic                  busy;
    logic                  done;
    logic                  fault;

    modport master (
        output enable, start, clear_fault, interlock_ok,
        output period, num_triggers, delay, width,
        input  trigger_out, counter, trigger_number_fixed, busy, done, fault
    );

    modport slave (
        input  enable, start, clear_fault, interlock_ok,
        input  period, num_triggers, delay, width,
        output trigger_out, counter, trigger_number_fixed, busy, done, fault
    );
endinterface

// File: rtl/trigger_sequencer.sv
// trigger_sequencer
// Multi-channel trigger scheduler. A period counter runs while in RUN and each
// channel is driven high inside its own delay/width window of every period,
// for a burst of num_triggers periods (0 = continuous). Configuration is
// captured into shadow registers at start. Losing the interlock blanks every
// trigger combinationally and latches a fault until explicitly cleared.
// Ports:
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : trigger_sequencer_if slave modport (control, config, status)
module trigger_sequencer #(
    parameter int CH    = 4,
    parameter int CNT_W = 32,
    parameter int NUM_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    trigger_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t                state_r;
    state_t                next_state_s;

    logic [CNT_W-1:0]      period_r;
    logic [NUM_W-1:0]      num_r;
    logic [CH*CNT_W-1:0]   delay_r;
    logic [CH*CNT_W-1:0]   width_r;

    logic [CNT_W-1:0]      counter_r;
    logic [NUM_W-1:0]      count_r;
    logic [CH-1:0]         trig_q_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  fault_r;

    logic                  start_ok_s;
    logic                  wrap_s;
    logic                  burst_end_s;
    logic [CNT_W:0]        cnt_ext_s;
    logic [CNT_W:0]        win_lo_s [CH];
    logic [CNT_W:0]        win_hi_s [CH];
    logic [CH-1:0]         window_s;

    assign start_ok_s  = bus.start && bus.enable && bus.interlock_ok &&
                         (bus.period != {CNT_W{1'b0}});
    assign wrap_s      = (counter_r == (period_r - CNT_W'(1)));
    // The wrap that brings the completed-period count up to num_r ends a burst
    assign burst_end_s = (num_r != {NUM_W{1'b0}}) && wrap_s &&
                         ((count_r + NUM_W'(1)) == num_r);
    assign cnt_ext_s   = {1'b0, counter_r};

    // Per-channel window, end computed one bit wider so delay+width cannot wrap
    always_comb begin
        window_s = {CH{1'b0}};
        win_lo_s = '{default: {(CNT_W+1){1'b0}}};
        win_hi_s = '{default: {(CNT_W+1){1'b0}}};
        for (int k = 0; k < CH; k++) begin
            win_lo_s[k] = {1'b0, delay_r[k*CNT_W +: CNT_W]};
            win_hi_s[k] = win_lo_s[k] + {1'b0, width_r[k*CNT_W +: CNT_W]};
            window_s[k] = (cnt_ext_s >= win_lo_s[k]) && (cnt_ext_s < win_hi_s[k]);
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; priority inside RUN is interlock > enable > burst end
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!bus.interlock_ok) begin
                    next_state_s = ST_FAULT;
                end else if (!bus.enable) begin
                    next_state_s = ST_IDLE;
                end else if (burst_end_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (!bus.interlock_ok) begin
                    next_state_s = ST_FAULT;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_FAULT: begin
                if (bus.clear_fault && bus.interlock_ok) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_FAULT;
                end
            end
            default: begin
                next_state_s = ST_FAULT;
            end
        endcase
    end

    // Shadow configuration, period counter, burst count and trigger pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_r  <= {CNT_W{1'b0}};
            num_r     <= {NUM_W{1'b0}};
            delay_r   <= {(CH*CNT_W){1'b0}};
            width_r   <= {(CH*CNT_W){1'b0}};
            counter_r <= {CNT_W{1'b0}};
            count_r   <= {NUM_W{1'b0}};
            trig_q_r  <= {CH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    trig_q_r <= {CH{1'b0}};
                    if (next_state_s == ST_RUN) begin
                        period_r  <= bus.period;
                        num_r     <= bus.num_triggers;
                        delay_r   <= bus.delay;
                        width_r   <= bus.width;
                        counter_r <= {CNT_W{1'b0}};
                        count_r   <= {NUM_W{1'b0}};
                    end
                end
                ST_RUN: begin
                    if ((next_state_s == ST_FAULT) || (next_state_s == ST_IDLE)) begin
                        // Abort: count holds, pipeline and position are dropped
                        trig_q_r  <= {CH{1'b0}};
                        counter_r <= {CNT_W{1'b0}};
                    end else begin
                        trig_q_r <= (next_state_s == ST_RUN) ? window_s : {CH{1'b0}};
                        if (wrap_s) begin
                            counter_r <= {CNT_W{1'b0}};
                            count_r   <= count_r + NUM_W'(1);
                        end else begin
                            counter_r <= counter_r + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    trig_q_r <= {CH{1'b0}};
                end
            endcase
        end
    end

    // Status flags registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            fault_r <= 1'b0;
        end else begin
            busy_r  <= (next_state_s == ST_RUN);
            done_r  <= (next_state_s == ST_DONE);
            fault_r <= (next_state_s == ST_FAULT);
        end
    end

    // Interlock gating stays combinational so a drop blanks triggers at once
    assign bus.trigger_out          = trig_q_r & {CH{bus.interlock_ok}} &
                                      {CH{state_r == ST_RUN}};
    assign bus.counter              = counter_r;
    assign bus.trigger_number_fixed = count_r;
    assign bus.busy                 = busy_r;
    assign bus.done                 = done_r;
    assign bus.fault                = fault_r;

endmodule

// File: tb/tb_trigger_sequencer.sv
module tb_trigger_sequencer;

    localparam int CH    = 4;
    localparam int CNT_W = 32;
    localparam int NUM_W = 32;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    trigger_sequencer_if #(.CH(CH), .CNT_W(CNT_W), .NUM_W(NUM_W)) bus ();

    trigger_sequencer #(.CH(CH), .CNT_W(CNT_W), .NUM_W(NUM_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_cfg(input int per, input int num,
                           input int d0, input int w0, input int d1, input int w1,
                           input int d2, input int w2, input int d3, input int w3);
        bus.period       = 32'(per);
        bus.num_triggers = 32'(num);
        bus.delay        = {32'(d3), 32'(d2), 32'(d1), 32'(d0)};
        bus.width        = {32'(w3), 32'(w2), 32'(w1), 32'(w0)};
    endtask

    // Called at a negedge; returns at the negedge of the first RUN cycle
    task automatic start_seq();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.enable = 1'b0; bus.start = 1'b0; bus.clear_fault = 1'b0;
        bus.interlock_ok = 1'b1;
        set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        n_cmp++;
        if ({bus.trigger_out, bus.counter, bus.trigger_number_fixed, bus.busy, bus.done, bus.fault} !== 71'd0) begin
            n_err++;
            $display("FAIL reset_init: got trig=%b cnt=%0d num=%0d busy=%b done=%b fault=%b, want all 0",
                     bus.trigger_out, bus.counter, bus.trigger_number_fixed, bus.busy, bus.done, bus.fault);
        end
        tick();
        rst = 1'b0;
        bus.enable = 1'b1;
        set_cfg(20, 0, 5, 5, 0, 0, 0, 0, 0, 0);
        start_seq();
        for (int i = 0; i < 7; i++) tick();
        n_cmp++;
        if (bus.counter !== 32'd7 || bus.trigger_out !== 4'b0001 || bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL reset_prerun: got cnt=%0d trig=%b busy=%b, want 7 0001 1",
                     bus.counter, bus.trigger_out, bus.busy);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.trigger_out, bus.counter, bus.trigger_number_fixed, bus.busy, bus.done, bus.fault} !== 71'd0) begin
            n_err++;
            $display("FAIL reset_async: got trig=%b cnt=%0d num=%0d busy=%b done=%b fault=%b, want all 0",
                     bus.trigger_out, bus.counter, bus.trigger_number_fixed, bus.busy, bus.done, bus.fault);
        end
        tick();
        rst = 1'b0;
        tick();
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.counter !== 32'd0) begin
            n_err++;
            $display("FAIL reset_idle: got busy=%b cnt=%0d, want 0 0", bus.busy, bus.counter);
        end
    endtask

    task automatic test_burst();
        logic [3:0]  exp_t;
        logic [31:0] exp_c;
        logic [31:0] exp_n;
        set_cfg(10, 3, 2, 3, 0, 0, 0, 0, 0, 0);
        start_seq();
        for (int i = 0; i < 30; i++) begin
            exp_c = 32'(i % 10);
            exp_n = 32'(i / 10);
            exp_t = (exp_c >= 32'd3 && exp_c <= 32'd5) ? 4'b0001 : 4'b0000;
            n_cmp++;
            if (bus.trigger_out !== exp_t || bus.counter !== exp_c ||
                bus.trigger_number_fixed !== exp_n || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                n_err++;
                $display("FAIL burst_cycle%0d: got trig=%b cnt=%0d num=%0d busy=%b done=%b, want %b %0d %0d 1 0",
                         i, bus.trigger_out, bus.counter, bus.trigger_number_fixed, bus.busy, bus.done,
                         exp_t, exp_c, exp_n);
            end
            tick();
        end
        n_cmp++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.trigger_number_fixed !== 32'd3 ||
            bus.counter !== 32'd0 || bus.trigger_out !== 4'b0000) begin
            n_err++;
            $display("FAIL burst_done: got done=%b busy=%b num=%0d cnt=%0d trig=%b, want 1 0 3 0 0000",
                     bus.done, bus.busy, bus.trigger_number_fixed, bus.counter, bus.trigger_out);
        end
        tick();
        n_cmp++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.trigger_number_fixed !== 32'd3) begin
            n_err++;
            $display("FAIL burst_after: got done=%b busy=%b num=%0d, want 0 0 3",
                     bus.done, bus.busy, bus.trigger_number_fixed);
        end
    endtask

    task automatic test_continuous();
        logic [3:0] exp_t;
        set_cfg(4, 0, 0, 0, 3, 5, 0, 0, 0, 0);
        start_seq();
        for (int i = 0; i < 40; i++) begin
            exp_t = (i >= 1 && ((i - 1) % 4) == 3) ? 4'b0010 : 4'b0000;
            n_cmp++;
            if (bus.trigger_out !== exp_t || bus.counter !== 32'(i % 4)) begin
                n_err++;
                $display("FAIL cont_cycle%0d: got trig=%b cnt=%0d, want %b %0d",
                         i, bus.trigger_out, bus.counter, exp_t, i % 4);
            end
            tick();
        end
        n_cmp++;
        if (bus.trigger_number_fixed !== 32'd10 || bus.busy !== 1'b1 || bus.counter !== 32'd0) begin
            n_err++;
            $display("FAIL cont_count: got num=%0d busy=%b cnt=%0d, want 10 1 0",
                     bus.trigger_number_fixed, bus.busy, bus.counter);
        end
        bus.enable = 1'b0;
        tick();
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.trigger_number_fixed !== 32'd10 ||
            bus.trigger_out !== 4'b0000) begin
            n_err++;
            $display("FAIL cont_abort: got busy=%b done=%b num=%0d trig=%b, want 0 0 10 0000",
                     bus.busy, bus.done, bus.trigger_number_fixed, bus.trigger_out);
        end
        tick();
        n_cmp++;
        if (bus.done !== 1'b0 || bus.fault !== 1'b0) begin
            n_err++;
            $display("FAIL cont_nodone: got done=%b fault=%b, want 0 0", bus.done, bus.fault);
        end
        bus.enable = 1'b1;
    endtask

    task automatic test_interlock();
        set_cfg(10, 0, 2, 3, 0, 0, 0, 0, 0, 0);
        start_seq();
        for (int i = 0; i < 3; i++) tick();
        n_cmp++;
        if (bus.trigger_out !== 4'b0001) begin
            n_err++;
            $display("FAIL il_pre: got trig=%b, want 0001", bus.trigger_out);
        end
        bus.interlock_ok = 1'b0;
        #1;
        n_cmp++;
        if (bus.trigger_out !== 4'b0000 || bus.fault !== 1'b0) begin
            n_err++;
            $display("FAIL il_gate: got trig=%b fault=%b, want 0000 0", bus.trigger_out, bus.fault);
        end
        tick();
        n_cmp++;
        if (bus.fault !== 1'b1 || bus.busy !== 1'b0 || bus.trigger_out !== 4'b0000) begin
            n_err++;
            $display("FAIL il_fault: got fault=%b busy=%b trig=%b, want 1 0 0000",
                     bus.fault, bus.busy, bus.trigger_out);
        end
        bus.clear_fault = 1'b1;
        tick();
        bus.clear_fault = 1'b0;
        tick();
        n_cmp++;
        if (bus.fault !== 1'b1) begin
            n_err++;
            $display("FAIL il_clear_blocked: got fault=%b, want 1", bus.fault);
        end
        bus.interlock_ok = 1'b1;
        start_seq();
        tick();
        n_cmp++;
        if (bus.fault !== 1'b1 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL il_start_in_fault: got fault=%b busy=%b, want 1 0", bus.fault, bus.busy);
        end
        bus.clear_fault = 1'b1;
        tick();
        bus.clear_fault = 1'b0;
        n_cmp++;
        if (bus.fault !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL il_clear: got fault=%b busy=%b, want 0 0", bus.fault, bus.busy);
        end
        tick();
    endtask

    task automatic test_final_wrap();
        set_cfg(3, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        start_seq();
        for (int i = 0; i < 5; i++) tick();
        n_cmp++;
        if (bus.counter !== 32'd2 || bus.trigger_number_fixed !== 32'd1) begin
            n_err++;
            $display("FAIL fw_pre: got cnt=%0d num=%0d, want 2 1", bus.counter, bus.trigger_number_fixed);
        end
        bus.interlock_ok = 1'b0;
        tick();
        n_cmp++;
        if (bus.fault !== 1'b1 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL fw_fault: got fault=%b done=%b busy=%b, want 1 0 0", bus.fault, bus.done, bus.busy);
        end
        tick();
        n_cmp++;
        if (bus.done !== 1'b0 || bus.fault !== 1'b1) begin
            n_err++;
            $display("FAIL fw_nodone: got done=%b fault=%b, want 0 1", bus.done, bus.fault);
        end
        bus.interlock_ok = 1'b1;
        bus.clear_fault  = 1'b1;
        tick();
        bus.clear_fault  = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        start_seq();
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.fault !== 1'b0) begin
            n_err++;
            $display("FAIL fw_period0: got busy=%b fault=%b, want 0 0", bus.busy, bus.fault);
        end
    endtask

    task automatic test_config_shadow();
        logic [3:0] exp_t;
        set_cfg(6, 2, 1, 2, 0, 0, 0, 0, 0, 0);
        start_seq();
        set_cfg(3, 5, 4, 2, 0, 0, 0, 5, 0, 0);
        for (int i = 0; i < 12; i++) begin
            exp_t = ((i % 6) == 2 || (i % 6) == 3) ? 4'b0001 : 4'b0000;
            n_cmp++;
            if (bus.trigger_out !== exp_t || bus.counter !== 32'(i % 6)) begin
                n_err++;
                $display("FAIL shadow_cycle%0d: got trig=%b cnt=%0d, want %b %0d",
                         i, bus.trigger_out, bus.counter, exp_t, i % 6);
            end
            tick();
        end
        n_cmp++;
        if (bus.done !== 1'b1 || bus.trigger_number_fixed !== 32'd2) begin
            n_err++;
            $display("FAIL shadow_done: got done=%b num=%0d, want 1 2", bus.done, bus.trigger_number_fixed);
        end
        tick();
    endtask

    task automatic test_period_one();
        set_cfg(1, 4, 0, 1, 0, 0, 0, 0, 0, 0);
        start_seq();
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (bus.counter !== 32'd0 || bus.trigger_number_fixed !== 32'(i) ||
                bus.trigger_out !== ((i >= 1) ? 4'b0001 : 4'b0000)) begin
                n_err++;
                $display("FAIL p1_cycle%0d: got cnt=%0d num=%0d trig=%b, want 0 %0d %b",
                         i, bus.counter, bus.trigger_number_fixed, bus.trigger_out,
                         i, (i >= 1) ? 4'b0001 : 4'b0000);
            end
            tick();
        end
        n_cmp++;
        if (bus.done !== 1'b1 || bus.trigger_number_fixed !== 32'd4) begin
            n_err++;
            $display("FAIL p1_done: got done=%b num=%0d, want 1 4", bus.done, bus.trigger_number_fixed);
        end
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_burst();
        test_continuous();
        test_interlock();
        test_final_wrap();
        test_config_shadow();
        test_period_one();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
